// File: rtl/bp_update_queue_pkg.sv
// Shared types for the branch-predictor update queue.
package bp_update_queue_pkg;

  localparam int unsigned BP_UPDQ_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_cond;
    logic        taken;
  } bp_update_t;

endpackage

// File: rtl/bp_updq_compact.sv
// Combinational lane compaction: packs eligible retire lanes into consecutive slots in lane order.
module bp_updq_compact
  import bp_update_queue_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 4
) (
  input  logic [COMMIT_WIDTH-1:0]      eligible,
  input  logic [COMMIT_WIDTH*32-1:0]   lane_pc,
  input  logic [COMMIT_WIDTH-1:0]      lane_is_cond,
  input  logic [COMMIT_WIDTH-1:0]      lane_taken,
  output bp_update_t                   entries [COMMIT_WIDTH],
  output logic [$clog2(COMMIT_WIDTH):0] n
);

  localparam int unsigned IdxW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
  localparam int unsigned NW   = $clog2(COMMIT_WIDTH) + 1;

  logic [IdxW-1:0] slot;

  always_comb begin
    entries = '{default: '0};
    slot    = '0;
    n       = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (eligible[i]) begin
        entries[slot] = '{pc: lane_pc[i*32 +: 32], is_cond: lane_is_cond[i], taken: lane_taken[i]};
        slot          = slot + IdxW'(1);
        n             = n + NW'(1);
      end
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// Commit-side branch-predictor update queue: compacts retire lanes into a FIFO, drains one per cycle.
// Define BP_UPDQ_COND_FILTER_EN to enqueue conditional branches only.
module bp_update_queue
  import bp_update_queue_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned DEPTH        = BP_UPDQ_DEPTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [COMMIT_WIDTH-1:0]    commit_valid_i,
  input  logic [COMMIT_WIDTH*32-1:0] commit_pc_i,
  input  logic [COMMIT_WIDTH-1:0]    commit_is_cond_i,
  input  logic [COMMIT_WIDTH-1:0]    commit_taken_i,
  output logic                       commit_ready_o,
  output logic                       update_valid_o,
  output logic [31:0]                update_pc_o,
  output logic                       update_is_cond_o,
  output logic                       update_taken_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned NW   = $clog2(COMMIT_WIDTH) + 1;
  // Ready needs room for a full-width commit, whatever n turns out to be.
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - COMMIT_WIDTH);

  bp_update_t        mem_q [DEPTH];
  logic [PtrW-1:0]   head_q;
  logic [PtrW-1:0]   tail_q;
  logic [CntW-1:0]   count_q;

  logic [COMMIT_WIDTH-1:0] eligible;
  bp_update_t              packed_entries [COMMIT_WIDTH];
  logic [NW-1:0]           enq_n;
  logic                    enq;
  logic                    deq;
  bp_update_t              head_entry;

`ifdef BP_UPDQ_COND_FILTER_EN
  assign eligible = commit_valid_i & commit_is_cond_i;
`else
  assign eligible = commit_valid_i;
`endif

  bp_updq_compact #(
    .COMMIT_WIDTH(COMMIT_WIDTH)
  ) u_compact (
    .eligible    (eligible),
    .lane_pc     (commit_pc_i),
    .lane_is_cond(commit_is_cond_i),
    .lane_taken  (commit_taken_i),
    .entries     (packed_entries),
    .n           (enq_n)
  );

  assign commit_ready_o = rst_i && !flush_i && (count_q <= ReadyMax);
  assign enq            = commit_ready_o && (enq_n != '0);
  assign deq            = rst_i && !flush_i && (count_q != '0);

  // Outputs are masked when idle so consumers never see stale head data.
  assign head_entry       = mem_q[head_q];
  assign update_valid_o   = deq;
  assign update_pc_o      = deq ? head_entry.pc : '0;
  assign update_is_cond_o = deq && head_entry.is_cond;
  assign update_taken_o   = deq && head_entry.taken;
  assign count_o          = rst_i ? count_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PtrW'(enq_n);
      if (deq) head_q <= head_q + PtrW'(1);
      count_q <= count_q + (enq ? CntW'(enq_n) : '0) - (deq ? CntW'(1) : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j < int'(enq_n)) mem_q[tail_q + PtrW'(j)] <= packed_entries[j];
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed self-checking bench for bp_update_queue (honours BP_UPDQ_COND_FILTER_EN).
module tb_bp_update_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   cv;
  logic [127:0] cpc;
  logic [3:0]   cc;
  logic [3:0]   ct;
  logic         commit_ready;
  logic         update_valid;
  logic [31:0]  update_pc;
  logic         update_is_cond;
  logic         update_taken;
  logic [4:0]   count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_update_queue #(
    .COMMIT_WIDTH(4),
    .DEPTH       (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .commit_valid_i  (cv),
    .commit_pc_i     (cpc),
    .commit_is_cond_i(cc),
    .commit_taken_i  (ct),
    .commit_ready_o  (commit_ready),
    .update_valid_o  (update_valid),
    .update_pc_o     (update_pc),
    .update_is_cond_o(update_is_cond),
    .update_taken_o  (update_taken),
    .count_o         (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] v, input logic [3:0] c, input logic [3:0] t,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] p2, input logic [31:0] p3);
    cv  = v;
    cc  = c;
    ct  = t;
    cpc = {p3, p2, p1, p0};
  endtask

  task automatic idle();
    offer(4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic expect_update(input string tag, input logic v, input logic [31:0] pc,
                               input logic c, input logic t);
    check({tag, "_valid"}, update_valid, v);
    check({tag, "_pc"}, update_pc, pc);
    check({tag, "_cond"}, update_is_cond, c);
    check({tag, "_taken"}, update_taken, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] sb [$];
  int          mc;
  int          seq;
  logic        offering;
  logic        exp_ready;
  logic [31:0] filt_pc [4];
  logic        filt_c [4];
  logic        filt_t [4];
  int          filt_n;

  initial begin
    // Reset held low while lanes are offered: everything reads zero.
    rst   = 1'b0;
    flush = 1'b0;
    offer(4'hF, 4'hF, 4'hF, 32'h10, 32'h14, 32'h18, 32'h1C);
    #1;
    check("rst_ready", commit_ready, 1'b0);
    check("rst_count", count, 0);
    expect_update("rst_upd", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ready2", commit_ready, 1'b0);
    check("rst_count2", count, 0);
    idle();
    rst = 1'b1;
    tick();
    check("idle_ready", commit_ready, 1'b1);
    check("idle_count", count, 0);
    check("idle_valid", update_valid, 1'b0);

    // Single lane 2.
    offer(4'b0100, 4'b0100, 4'b0100, 32'h0, 32'h0, 32'h8000_0010, 32'h0);
    #1;
    check("single_ready", commit_ready, 1'b1);
    tick();
    idle();
    expect_update("single", 1'b1, 32'h8000_0010, 1'b1, 1'b1);
    check("single_count", count, 1);
    tick();
    expect_update("single_after", 1'b0, 32'h0, 1'b0, 1'b0);
    check("single_count0", count, 0);

    // Sparse lanes {0,2,3} compact with no holes.
    offer(4'b1101, 4'b1111, 4'b0000, 32'h100, 32'hDEAD, 32'h108, 32'h10C);
    tick();
    idle();
    check("sparse_count0", count, 3);
    expect_update("sparse0", 1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    check("sparse_count1", count, 2);
    expect_update("sparse1", 1'b1, 32'h108, 1'b1, 1'b0);
    tick();
    check("sparse_count2", count, 1);
    expect_update("sparse2", 1'b1, 32'h10C, 1'b1, 1'b0);
    tick();
    check("sparse_count3", count, 0);
    check("sparse_valid3", update_valid, 1'b0);

    // Sustained full-width commit against a scoreboard, across pointer wrap.
    mc  = 0;
    seq = 0;
    for (int cyc = 0; cyc < 62; cyc++) begin
      offering  = (cyc < 40);
      exp_ready = (mc <= 12);
      if (offering)
        offer(4'hF, 4'hF, 4'b1010, 32'h1000 + seq * 4, 32'h1000 + (seq + 1) * 4,
              32'h1000 + (seq + 2) * 4, 32'h1000 + (seq + 3) * 4);
      else
        idle();
      #1;
      check("fill_ready", commit_ready, exp_ready);
      check("fill_count", count, mc);
      check("fill_valid", update_valid, mc != 0);
      if (mc != 0) check("fill_pc", update_pc, sb[0]);
      tick();
      if (mc != 0) begin
        void'(sb.pop_front());
        mc--;
      end
      if (offering && exp_ready) begin
        for (int k = 0; k < 4; k++) sb.push_back(32'h1000 + (seq + k) * 4);
        seq += 4;
        mc  += 4;
      end
    end
    idle();
    #1;
    check("fill_drained_valid", update_valid, 1'b0);
    check("fill_drained_count", count, 0);
    tick();

    // Flush at count 7 while offering lanes.
    offer(4'hF, 4'hF, 4'h0, 32'h300, 32'h304, 32'h308, 32'h30C);
    tick();
    offer(4'hF, 4'hF, 4'h0, 32'h310, 32'h314, 32'h318, 32'h31C);
    tick();
    check("flush_pre_count", count, 7);
    flush = 1'b1;
    offer(4'hF, 4'hF, 4'hF, 32'h320, 32'h324, 32'h328, 32'h32C);
    #1;
    check("flush_valid", update_valid, 1'b0);
    check("flush_ready", commit_ready, 1'b0);
    check("flush_pc", update_pc, 32'h0);
    tick();
    flush = 1'b0;
    idle();
    check("flush_count", count, 0);
    check("flush_valid_after", update_valid, 1'b0);
    tick();
    check("flush_valid_after2", update_valid, 1'b0);
    check("flush_count2", count, 0);

    // Conditional filter: is_cond = {1,0,1,0} for lanes 0..3.
`ifdef BP_UPDQ_COND_FILTER_EN
    filt_n = 2;
    filt_pc[0] = 32'h200; filt_c[0] = 1'b1; filt_t[0] = 1'b1;
    filt_pc[1] = 32'h208; filt_c[1] = 1'b1; filt_t[1] = 1'b0;
`else
    filt_n = 4;
    filt_pc[0] = 32'h200; filt_c[0] = 1'b1; filt_t[0] = 1'b1;
    filt_pc[1] = 32'h204; filt_c[1] = 1'b0; filt_t[1] = 1'b1;
    filt_pc[2] = 32'h208; filt_c[2] = 1'b1; filt_t[2] = 1'b0;
    filt_pc[3] = 32'h20C; filt_c[3] = 1'b0; filt_t[3] = 1'b0;
`endif
    offer(4'hF, 4'b0101, 4'b0011, 32'h200, 32'h204, 32'h208, 32'h20C);
    tick();
    idle();
    check("filt_count", count, filt_n);
    for (int k = 0; k < filt_n; k++) begin
      expect_update("filt", 1'b1, filt_pc[k], filt_c[k], filt_t[k]);
      tick();
    end
    check("filt_done_valid", update_valid, 1'b0);

    // Mid-stream reset discards pending updates and masks outputs while low.
    offer(4'hF, 4'hF, 4'hF, 32'h400, 32'h404, 32'h408, 32'h40C);
    tick();
    idle();
    check("mrst_pre_count", count, 4);
    check("mrst_pre_valid", update_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("mrst_ready", commit_ready, 1'b0);
    check("mrst_count", count, 0);
    expect_update("mrst_upd", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("mrst_post_count", count, 0);
    check("mrst_post_valid", update_valid, 1'b0);
    check("mrst_post_ready", commit_ready, 1'b1);
    tick();
    check("mrst_post_valid2", update_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
